// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
//
// Output-side partner of the PE control FSM. Accumulates signed partial sums
// across input-channel passes in a tile-length buffer. On the last channel
// each pixel is re-quantized (arithmetic shift, ReLU, saturate) and pushed
// into an output FIFO. After end_conv_in the block waits for the FIFO to
// drain and pulses conv_done.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   p_valid_in        partial-sum beat valid
//   last_chanel_in    beat belongs to the last input channel
//   psum_in           signed partial sum
//   end_conv_in       one-cycle pulse, convolution finished
//   cfg_shift         re-quantization right-shift amount, sampled per beat
//   out_valid/ready   FIFO head handshake
//   out_data          FIFO head (0 while empty)
//   conv_done         one-cycle pulse once the drain completes
//   ovf_err           sticky, a result was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module psum_accumulator #(
    parameter int unsigned TILE_LEN   = 28,
    parameter int unsigned PSUM_W     = 16,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid_in,
    input  logic              last_chanel_in,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              end_conv_in,
    input  logic [3:0]        cfg_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              conv_done,
    output logic              ovf_err
);

    localparam int unsigned IdxW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [IdxW-1:0] IdxLast = IdxW'(TILE_LEN - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                   state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic                     first_pass_q, first_pass_d;
    logic signed [ACC_W-1:0]  acc_buf_q [TILE_LEN];
    logic signed [ACC_W-1:0]  acc_buf_d [TILE_LEN];
    logic [OUT_W-1:0]         fifo_mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0]         fifo_mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]          count_q, count_d;
    logic                     ovf_err_q, ovf_err_d;

    // ------------------------------------------------------------------
    // Datapath: accumulate, saturate, re-quantize
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0]  acc_prev;
    logic [ACC_W:0]           sum_wide;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic [OUT_W-1:0]         q_val;

    always_comb begin
        // first_pass masks whatever is left in the buffer from earlier tiles
        acc_prev = first_pass_q ? '0 : acc_buf_q[idx_q];
        sum_wide = {acc_prev[ACC_W-1], acc_prev}
                 + {{(ACC_W + 1 - PSUM_W){psum_in[PSUM_W-1]}}, psum_in};

        // One guard bit: overflow when the two top bits disagree
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            acc_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                      : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            acc_sum = sum_wide[ACC_W-1:0];
        end

        shifted = acc_sum >>> cfg_shift;

        // ReLU, then clamp to the unsigned output range
        if (shifted[ACC_W-1]) begin
            q_val = '0;
        end else if (|shifted[ACC_W-2:OUT_W]) begin
            q_val = '1;
        end else begin
            q_val = shifted[OUT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic push, pop, fifo_full, push_ok;

    always_comb begin
        push      = p_valid_in && last_chanel_in;
        pop       = out_valid && out_ready;
        fifo_full = (count_q == CntFull);
        // A pop in the same cycle frees the slot the push needs
        push_ok   = push && (!fifo_full || pop);
    end

    // ------------------------------------------------------------------
    // Control FSM, pixel index and pass tracking
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        first_pass_d = first_pass_q;
        conv_done    = 1'b0;

        if (p_valid_in) begin
            if (idx_q == IdxLast) begin
                idx_d        = '0;
                first_pass_d = last_chanel_in;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end

        unique case (state_q)
            StRun: begin
                if (end_conv_in) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // end_conv_in is ignored here; completion realigns the tile
                if (count_q == '0) begin
                    state_d      = StRun;
                    conv_done    = 1'b1;
                    idx_d        = '0;
                    first_pass_d = 1'b1;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulation buffer write (non-last channels only)
    // ------------------------------------------------------------------
    always_comb begin
        acc_buf_d = acc_buf_q;
        if (p_valid_in && !last_chanel_in) begin
            acc_buf_d[idx_q] = acc_sum;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_err_d  = ovf_err_q;

        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = q_val;
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end
        if (push && !push_ok) begin
            ovf_err_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_comb begin
        out_valid = (count_q != '0);
        out_data  = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
        ovf_err   = ovf_err_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            idx_q        <= '0;
            first_pass_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            first_pass_q <= first_pass_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    // Storage arrays need no reset: first_pass and the FIFO count mask them
    always_ff @(posedge clk) begin
        acc_buf_q  <= acc_buf_d;
        fifo_mem_q <= fifo_mem_d;
    end

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

    localparam int TILE_LEN   = 28;
    localparam int PSUM_W     = 16;
    localparam int ACC_W      = 24;
    localparam int OUT_W      = 8;
    localparam int FIFO_DEPTH = 32;

    localparam longint AccMax = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint AccMin = -(longint'(1) << (ACC_W - 1));
    localparam longint OutMax = (longint'(1) << OUT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              p_valid_in = 1'b0;
    logic              last_chanel_in = 1'b0;
    logic [PSUM_W-1:0] psum_in = '0;
    logic              end_conv_in = 1'b0;
    logic [3:0]        cfg_shift = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic              conv_done;
    logic              ovf_err;

    psum_accumulator #(
        .TILE_LEN   (TILE_LEN),
        .PSUM_W     (PSUM_W),
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p_valid_in     (p_valid_in),
        .last_chanel_in (last_chanel_in),
        .psum_in        (psum_in),
        .end_conv_in    (end_conv_in),
        .cfg_shift      (cfg_shift),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .conv_done      (conv_done),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: per-pixel sums in an array, FIFO as a queue
    // ------------------------------------------------------------------
    longint m_acc [TILE_LEN];
    int     m_idx;
    bit     m_first;
    bit     m_drain;
    bit     m_ovf;
    longint m_q [$];

    // Observed DUT handshakes
    int     n_pops = 0;
    int     n_done_dut = 0;
    longint last_pop = -1;
    bit     rnd_ready = 1'b0;

    function automatic void model_reset();
        m_q.delete();
        m_idx   = 0;
        m_first = 1'b1;
        m_drain = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    always @(negedge clk) begin : monitor
        longint prev;
        longint s;
        longint qv;
        bit     done;
        if (rst_n) begin
            chk("out_valid", longint'(out_valid), longint'(m_q.size() != 0));
            if (m_q.size() != 0) chk("out_data", longint'(out_data), m_q[0]);
            chk("ovf_err", longint'(ovf_err), longint'(m_ovf));
            chk("conv_done", longint'(conv_done), longint'(m_drain && m_q.size() == 0));

            if (conv_done) n_done_dut++;
            if (out_valid && out_ready) begin
                n_pops++;
                last_pop = longint'(out_data);
            end

            // Advance the model across the coming edge
            done = m_drain && (m_q.size() == 0);
            if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
            if (p_valid_in) begin
                prev = m_first ? 0 : m_acc[m_idx];
                s = prev + longint'($signed(psum_in));
                if (s > AccMax) s = AccMax;
                else if (s < AccMin) s = AccMin;
                if (!last_chanel_in) begin
                    m_acc[m_idx] = s;
                end else begin
                    qv = s >>> cfg_shift;
                    if (qv < 0) qv = 0;
                    else if (qv > OutMax) qv = OutMax;
                    if (m_q.size() < FIFO_DEPTH) m_q.push_back(qv);
                    else m_ovf = 1'b1;
                end
                if (m_idx == TILE_LEN - 1) begin
                    m_idx   = 0;
                    m_first = last_chanel_in;
                end else begin
                    m_idx++;
                end
            end
            if (done) begin
                m_idx   = 0;
                m_first = 1'b1;
                m_drain = 1'b0;
            end else if (end_conv_in) begin
                m_drain = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------
    task automatic cyc(input bit v, input bit last, input int psum, input int sh);
        @(posedge clk);
        #1;
        p_valid_in     = v;
        last_chanel_in = last;
        psum_in        = PSUM_W'(psum);
        cfg_shift      = 4'(sh);
        end_conv_in    = 1'b0;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 0, 0);
    endtask

    task automatic pulse_end();
        @(posedge clk);
        #1;
        p_valid_in  = 1'b0;
        end_conv_in = 1'b1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pass(input int psum, input bit last, input int sh);
        for (int i = 0; i < TILE_LEN; i++) cyc(1'b1, last, psum, sh);
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = n_done_dut;
        for (int i = 0; i < budget && n_done_dut == start; i++) idle(1);
        idle(3);
        chk("conv_done_pulses", n_done_dut - start, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        p_valid_in  = 1'b0;
        end_conv_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Single-channel vectors: one beat, first pass, result 1 cycle later
    // ------------------------------------------------------------------
    typedef struct {
        int psum;
        int shift;
        int exp_out;
    } vec_t;

    vec_t tbl [14];

    initial begin : main
        int p0;
        int np;
        int sh;
        int ps;

        tbl[0]  = '{5, 0, 5};
        tbl[1]  = '{-5, 0, 0};
        tbl[2]  = '{300, 0, 255};
        tbl[3]  = '{300, 1, 150};
        tbl[4]  = '{-1, 0, 0};
        tbl[5]  = '{511, 1, 255};
        tbl[6]  = '{1000, 2, 250};
        tbl[7]  = '{32767, 15, 0};
        tbl[8]  = '{-32768, 3, 0};
        tbl[9]  = '{255, 0, 255};
        tbl[10] = '{256, 0, 255};
        tbl[11] = '{100, 3, 12};
        tbl[12] = '{32767, 7, 255};
        tbl[13] = '{-32768, 15, 0};

        model_reset();
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_conv_done", longint'(conv_done), 0);
        chk("rst_ovf_err", longint'(ovf_err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single channel ramp, outputs in order
        out_ready = 1'b1;
        p0 = n_pops;
        for (int i = 0; i < TILE_LEN; i++) cyc(1'b1, 1'b1, i, 0);
        idle(3);
        chk("ramp_pops", n_pops - p0, TILE_LEN);
        chk("ramp_last", last_pop, TILE_LEN - 1);

        // Table vectors
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 1'b1, tbl[i].psum, tbl[i].shift);
            idle(1);
            chk($sformatf("vec%0d_valid", i), longint'(out_valid), 1);
            chk($sformatf("vec%0d_data", i), longint'(out_data), tbl[i].exp_out);
        end
        idle(2);

        // end_conv with FIFO empty: conv_done exactly one cycle later
        pulse_end();
        idle(1);
        chk("empty_done_hi", longint'(conv_done), 1);
        idle(1);
        chk("empty_done_lo", longint'(conv_done), 0);

        // Three channels of 10, shift 1 -> 15
        p0 = n_pops;
        pass(10, 1'b0, 1);
        pass(10, 1'b0, 1);
        pass(10, 1'b1, 1);
        idle(3);
        chk("three_ch_pops", n_pops - p0, TILE_LEN);
        chk("three_ch_last", last_pop, 15);
        pulse_end();
        wait_done(50);

        // Negative, positive saturation, accumulator saturation
        pass(-5, 1'b1, 0);
        idle(3);
        chk("neg_relu", last_pop, 0);
        pass(32767, 1'b0, 0);
        pass(32767, 1'b1, 0);
        idle(3);
        chk("out_sat", last_pop, 255);
        for (int p = 0; p < 259; p++) pass(32767, 1'b0, 15);
        pass(32767, 1'b1, 15);
        idle(3);
        chk("acc_sat", last_pop, 255);

        // Back-pressure: 33 results into a 32-entry FIFO
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 33; i++) cyc(1'b1, 1'b1, 100 + i, 0);
        idle(2);
        chk("bp_ovf", longint'(ovf_err), 1);
        chk("bp_head", longint'(out_data), 100);
        pulse_end();
        idle(3);
        chk("bp_no_done_yet", longint'(conv_done), 0);
        p0 = n_pops;
        out_ready = 1'b1;
        wait_done(80);
        chk("bp_pops", n_pops - p0, 32);
        chk("bp_last", last_pop, 131);
        chk("bp_ovf_sticky", longint'(ovf_err), 1);

        // Reset mid-accumulation
        out_ready = 1'b0;
        cyc(1'b1, 1'b1, 1, 0);
        cyc(1'b1, 1'b1, 2, 0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 50, 0);
        idle(1);
        chk("pre_rst_valid", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        p_valid_in = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_data", longint'(out_data), 0);
        chk("mid_rst_done", longint'(conv_done), 0);
        chk("mid_rst_ovf", longint'(ovf_err), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        p0 = n_pops;
        pass(3, 1'b0, 0);
        pass(4, 1'b1, 0);
        idle(3);
        chk("post_rst_pops", n_pops - p0, TILE_LEN);
        chk("post_rst_val", last_pop, 7);

        // Full FIFO with simultaneous push and pop
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, i, 0);
        p0 = n_pops;
        cyc(1'b1, 1'b1, 200, 0);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(2);
        chk("full_pp_ovf", longint'(ovf_err), 0);
        chk("full_pp_head", longint'(out_data), 1);
        out_ready = 1'b1;
        idle(40);
        chk("full_pp_pops", n_pops - p0, 33);
        chk("full_pp_last", last_pop, 200);

        // Randomized convolutions against the model
        do_reset();
        rnd_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            np = int'($urandom_range(1, 4));
            sh = int'($urandom_range(0, 12));
            for (int p = 0; p < np; p++) begin
                for (int i = 0; i < TILE_LEN; i++) begin
                    if ($urandom_range(0, 4) == 0) idle(1);
                    ps = int'($urandom_range(0, 65535)) - 32768;
                    cyc(1'b1, (p == np - 1), ps, sh);
                end
            end
            pulse_end();
            wait_done(600);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Output-side partner of the PE control FSM. Consumes the partial-sum stream qualified by `p_valid` and `last_chanel`, accumulates partial sums across input-channel passes in a tile-length buffer, and on the last channel re-quantizes (shift, ReLU, saturate) each pixel. Results go into an output FIFO with a valid/ready handshake. The block detects `end_conv`, drains the FIFO, and reports completion to the top-level controller.

## Interface
Parameters:
- `TILE_LEN`, 28: pixels per channel pass (buffer depth).
- `PSUM_W`, 16: signed partial-sum input width.
- `ACC_W`, 24: signed accumulator width.
- `OUT_W`, 8: unsigned output width.
- `FIFO_DEPTH`, 32: output FIFO entries (power of 2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `p_valid_in`  in  1  partial-sum beat valid.
- `last_chanel_in`  in  1  beat belongs to last input channel; qualified by `p_valid_in`.
- `psum_in`  in  PSUM_W  signed partial sum.
- `end_conv_in`  in  1  one-cycle pulse, convolution finished.
- `cfg_shift`  in  4  right-shift amount for re-quantization; sampled per beat.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head.
- `out_data`  out  OUT_W  FIFO head.
- `conv_done`  out  1  one-cycle pulse, drain complete.
- `ovf_err`  out  1  sticky: push attempted while FIFO full.

## Operation
- Pixel index `idx`, 0..TILE_LEN-1. It increments on every `p_valid_in` beat and wraps to 0 after TILE_LEN-1.
- `first_pass` flag: set at reset. Cleared on the beat at `idx==TILE_LEN-1` with `last_chanel_in=0`. Set again on the beat at `idx==TILE_LEN-1` with `last_chanel_in=1`.
- Per beat, `sum = (first_pass ? 0 : buf[idx]) + sext(psum_in)`. The result saturates to the signed ACC_W range.
- Beat with `last_chanel_in=0`: `buf[idx] <= sum`.
- Beat with `last_chanel_in=1`: `buf[idx]` is left unchanged. The block computes `q = sum >>> cfg_shift` (arithmetic). It then applies ReLU (negative → 0) and saturates to [0, 2^OUT_W-1], and pushes `q` into the FIFO.
- State machine `{RUN, DRAIN}`:
  - Reset → RUN.
  - RUN → DRAIN on `end_conv_in`.
  - DRAIN → RUN on the cycle the FIFO is empty. That same cycle `conv_done` is pulsed, and `idx` and `first_pass` are reset to 0/1.
- In DRAIN, beats are still processed normally; a well-formed stream sends none.
- `end_conv_in` while already in DRAIN is ignored.
- FIFO:
  - Push is the write beat; pop is `out_valid && out_ready`.
  - Push while full without a same-cycle pop drops the data and sets `ovf_err`.
  - Push while full with a same-cycle pop is accepted.
  - Push and pop when empty: the push lands and `out_valid` rises next cycle.
- `ovf_err` clears only on reset.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `conv_done=0`, `ovf_err=0`.
  - `idx=0`, `first_pass=1`, FIFO empty, state RUN.
  - Buffer contents are don't-care, because `first_pass` masks them.
- Buffer read is combinational and the write is registered at the beat edge. Back-to-back beats at the same `idx` cannot occur (TILE_LEN ≥ 2). One beat per cycle is sustained.
- Latency from an emitting beat edge to `out_valid`/`out_data` is 1 cycle.
- `out_data` is stable while `out_valid && !out_ready`.
- `conv_done` is high exactly 1 cycle.
  - `end_conv_in` with the FIFO already empty: `conv_done` pulses 1 cycle after `end_conv_in`.
  - Otherwise it pulses in the cycle after the final pop.
- Reset asserted mid-pass or mid-drain returns all state to reset values asynchronously. Partial accumulation is discarded.

## Test plan
1. Single channel, `cfg_shift=0`, TILE_LEN beats with `last_chanel_in=1` and `psum_in=idx` → FIFO outputs 0,1,…,27 in order, `out_ready=1`, each 1 cycle after its beat.
2. Three channels, `psum_in=10` on every beat, last on the third pass, `cfg_shift=1` → 28 outputs of 15. Then send `end_conv_in` → `conv_done` pulses once after the FIFO empties.
3. Negative and saturation: `psum_in=-5` on a single last pass → 0; two passes of `psum_in=32767`, `cfg_shift=0` → 255. Separately, a 2^ACC_W overflow test yields 2^(ACC_W-1)-1 before the shift.
4. Back-pressure: hold `out_ready=0` and emit 33 results → first 32 stored, `ovf_err=1` sticky. Release `out_ready` → exactly 32 pops in order.
5. Full FIFO with simultaneous push and pop: fill 32, then beat with `out_ready=1` → no `ovf_err`, count stays 32.
6. Reset mid-accumulation: after 10 beats of pass 1, pulse `rst_n` low → all outputs 0. A new single-channel pass of `psum_in=7` yields 7, with no stale sums.
